wait_event_responder: RTL and testbench
=======================================

Name: wait_event_responder

Overview:
- Synthesizable responder engine for wait-on-event requests from the bench sequencer.
- Takes one request at a time: channel index, condition and timeout. It watches the selected monitored signal and returns a single response, either condition met, timeout or bad request.
- Sits between the sequencer's wait-command issuer (initiator side) and the bank of monitored DUT signals carried on the wait-event interface.

Parameters:
- WAIT_SIZE, 5, number of monitored channels
- WAIT_WIDTH, 32, width of each monitored channel
- TMO_WIDTH, 32, width of the timeout and elapsed-cycle counters
- IDX_WIDTH, $clog2(WAIT_SIZE), width of the channel-index field (minimum 1)

Ports:
- clk  in  1  bench clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- wait_signals  in  WAIT_SIZE x WAIT_WIDTH  monitored channels, already synchronous to clk
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_idx  in  IDX_WIDTH  channel select
- req_mode  in  3  0 RISE, 1 FALL, 2 HIGH, 3 LOW, 4 MATCH; 5-7 reserved
- req_bit  in  $clog2(WAIT_WIDTH)  bit used by RISE/FALL/HIGH/LOW
- req_value  in  WAIT_WIDTH  MATCH compare value
- req_mask  in  WAIT_WIDTH  MATCH compare mask (1 = compared)
- req_timeout  in  TMO_WIDTH  cycles allowed; 0 = wait forever
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts response
- rsp_status  out  2  0 DONE, 1 TIMEOUT, 2 BAD_REQ
- rsp_cycles  out  TMO_WIDTH  cycles from arm to completion, saturating at all-ones
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; req_ready = 1; rsp_valid = 0; rsp_status = 0; rsp_cycles = 0; busy = 0.
  - All captured request fields and the previous-sample register clear to 0.
- FSM states: IDLE, ARM, WAIT, RESP.
- IDLE:
  - req_ready = 1. A request is accepted when req_valid && req_ready; all req_* fields are captured on that edge.
  - If req_idx >= WAIT_SIZE or req_mode > 4, go to RESP with BAD_REQ and rsp_cycles = 0.
  - Otherwise go to ARM.
- ARM (exactly 1 cycle):
  - Capture the selected channel into the previous-sample register. This prevents a false edge on the first WAIT cycle.
  - Clear the elapsed counter to 0, then go to WAIT.
- WAIT:
  - Elapsed counter increments every cycle and saturates.
  - Conditions evaluated each cycle against the current sample:
    - RISE: prev bit = 0 and current bit = 1.
    - FALL: prev bit = 1 and current bit = 0.
    - HIGH: current bit = 1.
    - LOW: current bit = 0.
    - MATCH: (sample & mask) == (value & mask).
  - The previous-sample register updates every cycle.
  - When the condition holds in cycle n, go to RESP with DONE; rsp_valid is high from cycle n+1.
  - Timeout applies when req_timeout != 0 and the elapsed count reaches req_timeout with no condition: go to RESP with TIMEOUT.
  - If the condition and the timeout coincide in the same cycle, DONE wins.
- RESP:
  - rsp_valid = 1. rsp_status and rsp_cycles hold stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE; req_ready returns the following cycle.
- Level modes (HIGH/LOW/MATCH) already true at arm time complete on the first WAIT cycle with rsp_cycles = 1.
- req_ready is low in ARM, WAIT and RESP. No request queuing; the responder is strictly one request at a time.
- Asynchronous reset in any state aborts the wait with no response.
- Channel values must not change request handling once a request is captured; the captured fields are used throughout the request.

Decomposition:
- Shared package wait_event_pkg:
  - typedef enum for mode (RISE, FALL, HIGH, LOW, MATCH).
  - typedef enum for status (DONE, TIMEOUT, BAD_REQ).
  - typedef enum for FSM state.
  - Mode/status field widths.
- Natural sub-module: wait_cond_eval, combinational. Inputs: sample, prev sample, mode, bit, value, mask. Output: cond_met.
- The top module contains the channel mux, FSM, counter and output registers.

Test Plan:
- Reset → handshake → RISE:
  - Stimulus: hold rst_n low 5 cycles, release; issue idx=0, RISE, bit 0, timeout 0; drive channel 0 bit 0 high 10 cycles after arm.
  - Required: rsp_valid one cycle after the edge, DONE, rsp_cycles = 10; req_ready low until the response is accepted.
- TIMEOUT:
  - Stimulus: idx=1, FALL, bit 3, timeout 20; channel stays at 0xFFFF_FFFF.
  - Required: TIMEOUT, rsp_cycles = 20.
- MATCH with mask:
  - Stimulus: idx=2, MATCH, value 0xCAFE_0000, mask 0xFFFF_0000; channel steps 0x1234_5678 → 0xCAFE_DECA at cycle 7.
  - Required: DONE, rsp_cycles = 7.
- Level already true, plus rsp_ready stall:
  - Stimulus: HIGH on a bit already 1; hold rsp_ready low 4 cycles.
  - Required: DONE, rsp_cycles = 1; rsp_valid and status remain stable through the stall.
- Bad request and coincidence:
  - Stimulus 1: idx=5 with WAIT_SIZE=5. Required: BAD_REQ, rsp_cycles = 0.
  - Stimulus 2: RISE with timeout 8 and the edge at elapsed cycle 8. Required: DONE.
- Reset mid-wait:
  - Stimulus: assert rst_n during WAIT.
  - Required: outputs return to reset values asynchronously with no rsp_valid pulse; the next request after release completes normally.

Source files
------------

// File: rtl/wait_event_pkg.sv
// Shared types for the wait-on-event responder: request modes, response
// status codes and FSM states.
package wait_event_pkg;

    localparam int MODE_W   = 3;
    localparam int STATUS_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_RISE  = 3'd0,
        MODE_FALL  = 3'd1,
        MODE_HIGH  = 3'd2,
        MODE_LOW   = 3'd3,
        MODE_MATCH = 3'd4
    } mode_e;

    typedef enum logic [STATUS_W-1:0] {
        ST_DONE    = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_BAD_REQ = 2'd2
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    // Codes 5-7 are reserved and rejected at accept time.
    function automatic logic mode_is_valid(input logic [MODE_W-1:0] m);
        return m <= MODE_MATCH;
    endfunction

endpackage

// File: rtl/wait_cond_eval.sv
// Combinational condition check for one wait request against the current
// and previous sample of the selected channel.
module wait_cond_eval
    import wait_event_pkg::*;
#(
    parameter int WAIT_WIDTH = 32,
    parameter int BIT_WIDTH  = 5
) (
    input  logic [WAIT_WIDTH-1:0] sample,
    input  logic [WAIT_WIDTH-1:0] prev,
    input  logic [MODE_W-1:0]     mode,
    input  logic [BIT_WIDTH-1:0]  bit_sel,
    input  logic [WAIT_WIDTH-1:0] value,
    input  logic [WAIT_WIDTH-1:0] mask,
    output logic                  cond_met
);

    logic cur_bit;
    logic prv_bit;

    assign cur_bit = sample[bit_sel];
    assign prv_bit = prev[bit_sel];

    always_comb begin
        cond_met = 1'b0;
        case (mode)
            MODE_RISE:  cond_met = !prv_bit && cur_bit;
            MODE_FALL:  cond_met = prv_bit && !cur_bit;
            MODE_HIGH:  cond_met = cur_bit;
            MODE_LOW:   cond_met = !cur_bit;
            MODE_MATCH: cond_met = ((sample & mask) == (value & mask));
            default:    cond_met = 1'b0;
        endcase
    end

endmodule

// File: rtl/wait_event_responder.sv
// One-at-a-time wait-on-event responder: captures a request, watches the
// selected channel and returns DONE, TIMEOUT or BAD_REQ with elapsed cycles.
module wait_event_responder
    import wait_event_pkg::*;
#(
    parameter int WAIT_SIZE  = 5,
    parameter int WAIT_WIDTH = 32,
    parameter int TMO_WIDTH  = 32,
    parameter int IDX_WIDTH  = (WAIT_SIZE > 1) ? $clog2(WAIT_SIZE) : 1,
    parameter int BIT_WIDTH  = (WAIT_WIDTH > 1) ? $clog2(WAIT_WIDTH) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [WAIT_SIZE-1:0][WAIT_WIDTH-1:0] wait_signals,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [IDX_WIDTH-1:0]                 req_idx,
    input  logic [MODE_W-1:0]                    req_mode,
    input  logic [BIT_WIDTH-1:0]                 req_bit,
    input  logic [WAIT_WIDTH-1:0]                req_value,
    input  logic [WAIT_WIDTH-1:0]                req_mask,
    input  logic [TMO_WIDTH-1:0]                 req_timeout,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [STATUS_W-1:0]                  rsp_status,
    output logic [TMO_WIDTH-1:0]                 rsp_cycles,
    output logic                                 busy
);

    typedef struct packed {
        logic [IDX_WIDTH-1:0]  idx;
        logic [MODE_W-1:0]     mode;
        logic [BIT_WIDTH-1:0]  bit_sel;
        logic [WAIT_WIDTH-1:0] value;
        logic [WAIT_WIDTH-1:0] mask;
        logic [TMO_WIDTH-1:0]  timeout;
    } req_t;

    state_e                state, state_n;
    req_t                  cap;
    logic [WAIT_WIDTH-1:0] sample;
    logic [WAIT_WIDTH-1:0] prev;
    logic [TMO_WIDTH-1:0]  cnt;
    logic [TMO_WIDTH-1:0]  cnt_inc;
    logic                  cond_met;
    logic                  timeout_hit;
    logic                  req_bad;
    logic                  accept;
    logic                  finish;
    status_e               fin_status;
    logic [TMO_WIDTH-1:0]  fin_cycles;
    status_e               status_q;
    logic [TMO_WIDTH-1:0]  cycles_q;

    // Only the captured index drives the mux, so a changing req_idx cannot
    // disturb a request in flight.
    always_comb begin
        sample = '0;
        for (int i = 0; i < WAIT_SIZE; i++) begin
            if (int'(cap.idx) == i) sample = wait_signals[i];
        end
    end

    wait_cond_eval #(
        .WAIT_WIDTH (WAIT_WIDTH),
        .BIT_WIDTH  (BIT_WIDTH)
    ) u_eval (
        .sample   (sample),
        .prev     (prev),
        .mode     (cap.mode),
        .bit_sel  (cap.bit_sel),
        .value    (cap.value),
        .mask     (cap.mask),
        .cond_met (cond_met)
    );

    assign cnt_inc     = (cnt == '1) ? cnt : cnt + 1'b1;
    assign timeout_hit = (cap.timeout != '0) && (cnt_inc == cap.timeout);
    assign req_bad     = (int'(req_idx) >= WAIT_SIZE) || !mode_is_valid(req_mode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        finish     = 1'b0;
        fin_status = ST_DONE;
        fin_cycles = cnt_inc;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_bad) begin
                        state_n    = S_RESP;
                        finish     = 1'b1;
                        fin_status = ST_BAD_REQ;
                        fin_cycles = '0;
                    end else begin
                        state_n = S_ARM;
                    end
                end
            end
            S_ARM: state_n = S_WAIT;
            S_WAIT: begin
                // A condition seen on the timeout cycle still counts as DONE.
                if (cond_met) begin
                    state_n    = S_RESP;
                    finish     = 1'b1;
                    fin_status = ST_DONE;
                end else if (timeout_hit) begin
                    state_n    = S_RESP;
                    finish     = 1'b1;
                    fin_status = ST_TIMEOUT;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap      <= '0;
            prev     <= '0;
            cnt      <= '0;
            status_q <= ST_DONE;
            cycles_q <= '0;
        end else begin
            if (accept) begin
                cap.idx     <= req_idx;
                cap.mode    <= req_mode;
                cap.bit_sel <= req_bit;
                cap.value   <= req_value;
                cap.mask    <= req_mask;
                cap.timeout <= req_timeout;
            end
            // Seeding prev in ARM keeps the first WAIT cycle from seeing a
            // phantom edge against a stale sample.
            if (state == S_ARM) begin
                prev <= sample;
                cnt  <= '0;
            end else if (state == S_WAIT) begin
                prev <= sample;
                cnt  <= cnt_inc;
            end
            if (finish) begin
                status_q <= fin_status;
                cycles_q <= fin_cycles;
            end
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign rsp_valid  = (state == S_RESP);
    assign busy       = (state != S_IDLE);
    assign rsp_status = status_q;
    assign rsp_cycles = cycles_q;

endmodule

// File: tb/tb_wait_event_responder.sv
// Scoreboard bench for wait_event_responder: each scenario pushes its
// expected response when it issues a request and pops it on the response.
module tb_wait_event_responder;

    localparam int WS = 5;
    localparam int WW = 32;
    localparam int TW = 32;

    typedef struct {
        logic [1:0]    st;
        logic [TW-1:0] cyc;
        string         name;
    } exp_t;

    logic                   clk;
    logic                   rst_n;
    logic [WS-1:0][WW-1:0]  ws;
    logic                   req_valid;
    logic                   req_ready;
    logic [2:0]             req_idx;
    logic [2:0]             req_mode;
    logic [4:0]             req_bit;
    logic [WW-1:0]          req_value;
    logic [WW-1:0]          req_mask;
    logic [TW-1:0]          req_timeout;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_status;
    logic [TW-1:0]          rsp_cycles;
    logic                   busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    wait_event_responder #(.WAIT_SIZE(WS), .WAIT_WIDTH(WW), .TMO_WIDTH(TW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wait_signals (ws),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_idx      (req_idx),
        .req_mode     (req_mode),
        .req_bit      (req_bit),
        .req_value    (req_value),
        .req_mask     (req_mask),
        .req_timeout  (req_timeout),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_status   (rsp_status),
        .rsp_cycles   (rsp_cycles),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] idx, input logic [2:0] mode, input logic [4:0] b,
                         input logic [WW-1:0] val, input logic [WW-1:0] msk,
                         input logic [TW-1:0] tmo, input string name);
        int n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (!req_ready) begin
            n_fail++;
            $display("FAIL %s: req_ready never rose (got %b, need 1)", name, req_ready);
        end
        req_idx = idx; req_mode = mode; req_bit = b;
        req_value = val; req_mask = msk; req_timeout = tmo;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Bounded wait for rsp_valid; leaves sampling at #1 after an edge.
    task automatic wait_rsp(input int limit, output logic got);
        got = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (rsp_valid) got = 1'b1;
    endtask

    task automatic accept_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_ctl: ready/valid/busy=%b need 100", {req_ready, rsp_valid, busy});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (rsp_status !== 2'd0 || rsp_cycles !== '0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: status=%0d cycles=%0d ready=%b busy=%b need 0 0 1 0",
                     rsp_status, rsp_cycles, req_ready, busy);
        end
    endtask

    task automatic test_rise();
        logic got;
        exp_t e;
        ws[0] = 32'h0;
        issue(3'd0, 3'd0, 5'd0, '0, '0, '0, "rise");
        sb.push_back('{2'd0, 32'd10, "rise"});
        n_checks++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rise_busy: ready=%b busy=%b need 0 1", req_ready, busy);
        end
        repeat (10) @(posedge clk);
        #1;
        ws[0][0] = 1'b1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_early: valid=%b ready=%b need 0 0", rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        wait_rsp(1, got);
        e = sb.pop_front();
        n_checks++;
        if (!got || rsp_status !== e.st || rsp_cycles !== e.cyc) begin
            n_fail++;
            $display("FAIL %s: valid=%b status=%0d cycles=%0d need 1 %0d %0d",
                     e.name, got, rsp_status, rsp_cycles, e.st, e.cyc);
        end
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rise_ready_resp: req_ready=%b need 0", req_ready);
        end
        accept_rsp();
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rise_release: valid=%b ready=%b need 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_timeout();
        logic got;
        exp_t e;
        ws[1] = 32'hFFFF_FFFF;
        issue(3'd1, 3'd1, 5'd3, '0, '0, 32'd20, "timeout");
        sb.push_back('{2'd1, 32'd20, "timeout"});
        wait_rsp(100, got);
        e = sb.pop_front();
        n_checks++;
        if (!got || rsp_status !== e.st || rsp_cycles !== e.cyc) begin
            n_fail++;
            $display("FAIL %s: valid=%b status=%0d cycles=%0d need 1 %0d %0d",
                     e.name, got, rsp_status, rsp_cycles, e.st, e.cyc);
        end
        accept_rsp();
    endtask

    task automatic test_match();
        logic got;
        exp_t e;
        ws[2] = 32'h1234_5678;
        issue(3'd2, 3'd4, 5'd0, 32'hCAFE_0000, 32'hFFFF_0000, '0, "match");
        sb.push_back('{2'd0, 32'd7, "match"});
        repeat (7) @(posedge clk);
        #1;
        ws[2] = 32'hCAFE_DECA;
        wait_rsp(20, got);
        e = sb.pop_front();
        n_checks++;
        if (!got || rsp_status !== e.st || rsp_cycles !== e.cyc) begin
            n_fail++;
            $display("FAIL %s: valid=%b status=%0d cycles=%0d need 1 %0d %0d",
                     e.name, got, rsp_status, rsp_cycles, e.st, e.cyc);
        end
        accept_rsp();
    endtask

    task automatic test_level_stall();
        logic got;
        exp_t e;
        ws[3] = 32'h0000_0010;
        issue(3'd3, 3'd2, 5'd4, '0, '0, '0, "level");
        sb.push_back('{2'd0, 32'd1, "level"});
        wait_rsp(20, got);
        e = sb.pop_front();
        n_checks++;
        if (!got || rsp_status !== e.st || rsp_cycles !== e.cyc) begin
            n_fail++;
            $display("FAIL %s: valid=%b status=%0d cycles=%0d need 1 %0d %0d",
                     e.name, got, rsp_status, rsp_cycles, e.st, e.cyc);
        end
        ws[3] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_status !== e.st || rsp_cycles !== e.cyc) begin
                n_fail++;
                $display("FAIL stall_%0d: valid=%b status=%0d cycles=%0d need 1 %0d %0d",
                         i, rsp_valid, rsp_status, rsp_cycles, e.st, e.cyc);
            end
        end
        accept_rsp();
    endtask

    task automatic test_bad_req();
        logic got;
        exp_t e;
        issue(3'd5, 3'd0, 5'd0, '0, '0, 32'd3, "bad_idx");
        sb.push_back('{2'd2, 32'd0, "bad_idx"});
        wait_rsp(5, got);
        e = sb.pop_front();
        n_checks++;
        if (!got || rsp_status !== e.st || rsp_cycles !== e.cyc) begin
            n_fail++;
            $display("FAIL %s: valid=%b status=%0d cycles=%0d need 1 %0d %0d",
                     e.name, got, rsp_status, rsp_cycles, e.st, e.cyc);
        end
        accept_rsp();
        issue(3'd0, 3'd7, 5'd0, '0, '0, '0, "bad_mode");
        sb.push_back('{2'd2, 32'd0, "bad_mode"});
        wait_rsp(5, got);
        e = sb.pop_front();
        n_checks++;
        if (!got || rsp_status !== e.st || rsp_cycles !== e.cyc) begin
            n_fail++;
            $display("FAIL %s: valid=%b status=%0d cycles=%0d need 1 %0d %0d",
                     e.name, got, rsp_status, rsp_cycles, e.st, e.cyc);
        end
        accept_rsp();
    endtask

    task automatic test_coincide();
        logic got;
        exp_t e;
        ws[4] = 32'h0;
        issue(3'd4, 3'd0, 5'd2, '0, '0, 32'd8, "coincide");
        sb.push_back('{2'd0, 32'd8, "coincide"});
        repeat (8) @(posedge clk);
        #1;
        ws[4][2] = 1'b1;
        wait_rsp(20, got);
        e = sb.pop_front();
        n_checks++;
        if (!got || rsp_status !== e.st || rsp_cycles !== e.cyc) begin
            n_fail++;
            $display("FAIL %s: valid=%b status=%0d cycles=%0d need 1 %0d %0d",
                     e.name, got, rsp_status, rsp_cycles, e.st, e.cyc);
        end
        accept_rsp();
    endtask

    task automatic test_reset_mid_wait();
        logic got;
        logic seen;
        exp_t e;
        ws[0] = 32'h0000_0001;
        issue(3'd0, 3'd0, 5'd5, '0, '0, '0, "abort");
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy: busy=%b need 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, busy} !== 3'b100 || rsp_status !== 2'd0 || rsp_cycles !== '0) begin
            n_fail++;
            $display("FAIL abort_async: ready/valid/busy=%b status=%0d cycles=%0d need 100 0 0",
                     {req_ready, rsp_valid, busy}, rsp_status, rsp_cycles);
        end
        seen = 1'b0;
        ws[0][5] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_rsp: rsp_valid pulse seen=%b need 0", seen);
        end
        issue(3'd0, 3'd2, 5'd0, '0, '0, '0, "after_reset");
        sb.push_back('{2'd0, 32'd1, "after_reset"});
        wait_rsp(20, got);
        e = sb.pop_front();
        n_checks++;
        if (!got || rsp_status !== e.st || rsp_cycles !== e.cyc) begin
            n_fail++;
            $display("FAIL %s: valid=%b status=%0d cycles=%0d need 1 %0d %0d",
                     e.name, got, rsp_status, rsp_cycles, e.st, e.cyc);
        end
        accept_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ws = '0;
        req_valid = 1'b0; req_idx = '0; req_mode = '0; req_bit = '0;
        req_value = '0; req_mask = '0; req_timeout = '0;
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_rise();
        test_timeout();
        test_match();
        test_level_stall();
        test_bad_req();
        test_coincide();
        test_reset_mid_wait();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, need 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
